// File: rtl/qtree_launch_sequencer.sv
// qtree_launch_sequencer: run controller between the QTree stream loaders and a
// generated kernel. It waits for every argument tree to be loaded into the heap
// and snapshots the root pointers. It then issues the Go token and one pointer
// token per argument, each on an independent valid/ready channel. It captures
// the result pointer, measures run latency and re-arms the loaders in DONE.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_start           run request, honoured in IDLE and DONE only
//   i_arg_loaded      per-argument loader-complete level
//   i_arg_ptr         root pointer per argument (slice k = argument k)
//   o_loader_clear    one-cycle pulse on DONE entry, re-arms all loaders
//   o_go_d / i_go_r   Go token valid / ready
//   o_args_d          argument tokens, slice k bit 0 = valid
//   i_args_r          per-argument ready
//   i_res_d           result token, bit 0 = valid
//   o_res_r           result ready (combinational)
//   o_result_data     captured result pointer
//   o_busy, o_done    run in progress / run finished
//   o_run_cycles      saturating LAUNCH-entry-to-capture cycle count
module qtree_launch_sequencer #(
  parameter int unsigned NARGS = 3,
  parameter int unsigned PTR_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [NARGS-1:0]       i_arg_loaded,
  input  logic [NARGS*PTR_W-1:0] i_arg_ptr,
  output logic                   o_loader_clear,
  output logic                   o_go_d,
  input  logic                   i_go_r,
  output logic [NARGS*PTR_W-1:0] o_args_d,
  input  logic [NARGS-1:0]       i_args_r,
  input  logic [PTR_W-1:0]       i_res_d,
  output logic                   o_res_r,
  output logic [PTR_W-1:0]       o_result_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_W-1:0]       o_run_cycles
);

  localparam int unsigned ARGS_W = NARGS * PTR_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_LAUNCH    = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Registered state
  state_t             r_state;
  logic [ARGS_W-1:0]  r_ptr;
  logic               r_go_d;
  logic [ARGS_W-1:0]  r_args_d;
  logic               r_go_sent;
  logic [NARGS-1:0]   r_arg_sent;
  logic               r_res_got;
  logic [PTR_W-1:0]   r_result_data;
  logic [CNT_W-1:0]   r_run_cycles;
  logic               r_busy;
  logic               r_done;
  logic               r_loader_clear;

  // Next-state values
  state_t             w_state_n;
  logic [ARGS_W-1:0]  w_ptr_n;
  logic               w_go_d_n;
  logic [ARGS_W-1:0]  w_args_d_n;
  logic               w_go_sent_n;
  logic [NARGS-1:0]   w_arg_sent_n;
  logic               w_res_got_n;
  logic [PTR_W-1:0]   w_result_data_n;
  logic [CNT_W-1:0]   w_run_cycles_n;
  logic               w_busy_n;
  logic               w_done_n;
  logic               w_loader_clear_n;
  logic               w_res_r;
  logic               w_capture;
  logic               w_all_sent;

  // Next-state and next-output logic
  always_comb begin
    w_state_n        = r_state;
    w_ptr_n          = r_ptr;
    w_go_sent_n      = r_go_sent;
    w_arg_sent_n     = r_arg_sent;
    w_res_got_n      = r_res_got;
    w_result_data_n  = r_result_data;
    w_run_cycles_n   = r_run_cycles;
    w_go_d_n         = 1'b0;
    w_args_d_n       = '0;
    w_busy_n         = 1'b0;
    w_done_n         = 1'b0;
    w_loader_clear_n = 1'b0;
    w_res_r          = 1'b0;
    w_capture        = 1'b0;
    w_all_sent       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_n = S_WAIT_LOAD;
      end

      S_WAIT_LOAD: begin
        if (&i_arg_loaded) begin
          // Snapshot roots with the token-valid bit forced on
          w_ptr_n = i_arg_ptr;
          for (int unsigned k = 0; k < NARGS; k++) begin
            w_ptr_n[k*PTR_W] = 1'b1;
          end
          w_go_sent_n    = 1'b0;
          w_arg_sent_n   = '0;
          w_res_got_n    = 1'b0;
          w_run_cycles_n = '0;
          w_state_n      = S_LAUNCH;
        end
      end

      S_LAUNCH, S_RUN: begin
        // Result may be taken any time after launch, until captured once
        w_res_r   = ~r_res_got;
        w_capture = w_res_r & i_res_d[0];
        if (!r_res_got) begin
          w_run_cycles_n = (r_run_cycles == {CNT_W{1'b1}}) ? r_run_cycles
                                                            : r_run_cycles + CNT_W'(1);
        end
        if (w_capture) begin
          w_res_got_n     = 1'b1;
          w_result_data_n = i_res_d;
        end
        // Sticky per-channel sent flags; channels finish in any order
        w_go_sent_n = r_go_sent | (r_go_d & i_go_r);
        for (int unsigned k = 0; k < NARGS; k++) begin
          w_arg_sent_n[k] = r_arg_sent[k] | (r_args_d[k*PTR_W] & i_args_r[k]);
        end
        w_all_sent = w_go_sent_n & (&w_arg_sent_n);
        if (w_all_sent) w_state_n = w_res_got_n ? S_DONE : S_RUN;
      end

      S_DONE: begin
        if (i_start) w_state_n = S_WAIT_LOAD;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Channel valids are high in LAUNCH until that channel's own transfer
    if (w_state_n == S_LAUNCH) begin
      w_go_d_n = ~w_go_sent_n;
      for (int unsigned k = 0; k < NARGS; k++) begin
        if (!w_arg_sent_n[k]) w_args_d_n[k*PTR_W +: PTR_W] = w_ptr_n[k*PTR_W +: PTR_W];
      end
    end

    w_busy_n         = (w_state_n == S_WAIT_LOAD) || (w_state_n == S_LAUNCH) ||
                       (w_state_n == S_RUN);
    w_done_n         = (w_state_n == S_DONE);
    w_loader_clear_n = (w_state_n == S_DONE) && (r_state != S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_go_d         <= 1'b0;
      r_args_d       <= '0;
      r_go_sent      <= 1'b0;
      r_arg_sent     <= '0;
      r_res_got      <= 1'b0;
      r_result_data  <= '0;
      r_run_cycles   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_loader_clear <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_ptr          <= w_ptr_n;
      r_go_d         <= w_go_d_n;
      r_args_d       <= w_args_d_n;
      r_go_sent      <= w_go_sent_n;
      r_arg_sent     <= w_arg_sent_n;
      r_res_got      <= w_res_got_n;
      r_result_data  <= w_result_data_n;
      r_run_cycles   <= w_run_cycles_n;
      r_busy         <= w_busy_n;
      r_done         <= w_done_n;
      r_loader_clear <= w_loader_clear_n;
    end
  end

  assign o_loader_clear = r_loader_clear;
  assign o_go_d         = r_go_d;
  assign o_args_d       = r_args_d;
  assign o_res_r        = w_res_r;
  assign o_result_data  = r_result_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_run_cycles   = r_run_cycles;

endmodule
